// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : hazard_ctrl_if                                             |
// | Description : Hazard-controller bundle: ID/EX operand info and the       |
// |               stage enables/flushes. Optional: HAZARD_PERF_EN            |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface hazard_ctrl_if #(
    parameter int RA_W = 5
);
    logic [RA_W-1:0] id_rs1;
    logic [RA_W-1:0] id_rs2;
    logic            id_rs1_used;
    logic            id_rs2_used;
    logic [RA_W-1:0] ex_rd;
    logic            ex_mem_read;
    logic            br_taken;
    logic            dmem_busy;
    logic            pc_write;
    logic            ifid_write;
    logic            ifid_flush;
    logic            idex_flush;
    logic            exmem_write;
    logic            memwb_flush;
    logic            mem_fault;
`ifdef HAZARD_PERF_EN
    logic [31:0]     stall_cnt;
    logic [31:0]     flush_cnt;
`endif

    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_mem_read,
               br_taken, dmem_busy,
`ifdef HAZARD_PERF_EN
        input  stall_cnt, flush_cnt,
`endif
        input  pc_write, ifid_write, ifid_flush, idex_flush, exmem_write,
               memwb_flush, mem_fault
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_mem_read,
               br_taken, dmem_busy,
`ifdef HAZARD_PERF_EN
        output stall_cnt, flush_cnt,
`endif
        output pc_write, ifid_write, ifid_flush, idex_flush, exmem_write,
               memwb_flush, mem_fault
    );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : hazard_ctrl                                                |
// | Description : 5-stage RV32I hazard/stall controller with dmem watchdog.  |
// |               Optional stall/flush counters: HAZARD_PERF_EN              |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module hazard_ctrl #(
    parameter int RA_W    = 5,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave hz
);
    localparam logic [1:0]      c_st_run      = 2'd0;
    localparam logic [1:0]      c_st_mem_wait = 2'd1;
    localparam logic [1:0]      c_st_fault    = 2'd2;
    localparam logic [7:0]      c_timeout     = 8'(TIMEOUT);
    localparam logic [RA_W-1:0] c_ra_zero     = '0;

    logic [1:0] r_state;
    logic [7:0] r_wait_cnt;
    logic       r_br_pend;

    logic w_load_use;
    logic w_branch;
    logic w_freeze;
    logic w_pc_write;
    logic w_ifid_write;
    logic w_ifid_flush;
    logic w_idex_flush;
    logic w_exmem_write;
    logic w_memwb_flush;

    assign w_load_use = hz.ex_mem_read && (hz.ex_rd != c_ra_zero) &&
                        ((hz.id_rs1_used && (hz.id_rs1 == hz.ex_rd)) ||
                         (hz.id_rs2_used && (hz.id_rs2 == hz.ex_rd)));
    assign w_branch   = hz.br_taken || r_br_pend;
    assign w_freeze   = (r_state == c_st_fault) || hz.dmem_busy;

    // Priority: memory freeze, then branch flush, then load-use bubble.
    always_comb begin
        w_pc_write    = 1'b1;
        w_ifid_write  = 1'b1;
        w_ifid_flush  = 1'b0;
        w_idex_flush  = 1'b0;
        w_exmem_write = 1'b1;
        w_memwb_flush = 1'b0;
        if (w_freeze) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_exmem_write = 1'b0;
            w_memwb_flush = 1'b1;
        end else if (w_branch) begin
            w_ifid_flush  = 1'b1;
            w_idex_flush  = 1'b1;
        end else if (w_load_use) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_flush  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_run;
            r_wait_cnt <= 8'd0;
            r_br_pend  <= 1'b0;
        end else begin
            case (r_state)
                c_st_run: begin
                    if (hz.dmem_busy) begin
                        r_state    <= c_st_mem_wait;
                        r_wait_cnt <= 8'd1;
                        if (hz.br_taken) r_br_pend <= 1'b1;
                    end else if (w_branch) begin
                        r_br_pend  <= 1'b0;
                    end
                end
                c_st_mem_wait: begin
                    if (hz.dmem_busy) begin
                        if (r_wait_cnt != 8'hFF) r_wait_cnt <= r_wait_cnt + 8'd1;
                        if (r_wait_cnt >= c_timeout) r_state <= c_st_fault;
                        if (hz.br_taken) r_br_pend <= 1'b1;
                    end else begin
                        // Any pending branch is flushed by this cycle's outputs.
                        r_state    <= c_st_run;
                        r_wait_cnt <= 8'd0;
                        r_br_pend  <= 1'b0;
                    end
                end
                c_st_fault: r_state <= c_st_fault;
                default:    r_state <= c_st_run;
            endcase
        end
    end

    assign hz.pc_write    = w_pc_write;
    assign hz.ifid_write  = w_ifid_write;
    assign hz.ifid_flush  = w_ifid_flush;
    assign hz.idex_flush  = w_idex_flush;
    assign hz.exmem_write = w_exmem_write;
    assign hz.memwb_flush = w_memwb_flush;
    assign hz.mem_fault   = (r_state == c_st_fault);

`ifdef HAZARD_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            if (!w_pc_write)  r_stall_cnt <= r_stall_cnt + 32'd1;
            if (w_ifid_flush) r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign hz.stall_cnt = r_stall_cnt;
    assign hz.flush_cnt = r_flush_cnt;
`endif
endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_hazard_ctrl                                             |
// | Description : Directed, table-driven bench for hazard_ctrl (TIMEOUT=4).  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_hazard_ctrl;
    localparam int RA_W    = 5;
    localparam int TIMEOUT = 4;

    // {pc_write, ifid_write, ifid_flush, idex_flush, exmem_write, memwb_flush, mem_fault}
    localparam logic [6:0] c_def = 7'b1100100;
    localparam logic [6:0] c_lu  = 7'b0001100;
    localparam logic [6:0] c_br  = 7'b1111100;
    localparam logic [6:0] c_frz = 7'b0000010;
    localparam logic [6:0] c_flt = 7'b0000011;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       rs1_used;
        logic       rs2_used;
        logic [4:0] ex_rd;
        logic       mem_read;
        logic       br;
        logic       busy;
        logic [6:0] exp;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    hazard_ctrl_if #(.RA_W(RA_W)) hz ();

    hazard_ctrl #(.RA_W(RA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] outs();
        return {hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.idex_flush,
                hz.exmem_write, hz.memwb_flush, hz.mem_fault};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled 1 ns later.
    task automatic drive(input vec_t v);
        @(negedge clk);
        hz.id_rs1      = v.rs1;
        hz.id_rs2      = v.rs2;
        hz.id_rs1_used = v.rs1_used;
        hz.id_rs2_used = v.rs2_used;
        hz.ex_rd       = v.ex_rd;
        hz.ex_mem_read = v.mem_read;
        hz.br_taken    = v.br;
        hz.dmem_busy   = v.busy;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t vecs[19];
    vec_t v;

    initial begin
        checks = 0;
        errors = 0;
        //          rs1 rs2 u1 u2 exrd ld br busy exp
        vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, c_def};
        vecs[1]  = '{5, 0, 1, 0, 5, 1, 0, 0, c_lu};
        vecs[2]  = '{5, 0, 1, 0, 5, 0, 0, 0, c_def};
        vecs[3]  = '{0, 0, 1, 0, 0, 1, 0, 0, c_def};
        vecs[4]  = '{1, 7, 0, 1, 7, 1, 0, 0, c_lu};
        vecs[5]  = '{3, 7, 1, 0, 7, 1, 0, 0, c_def};
        vecs[6]  = '{5, 0, 1, 0, 5, 1, 1, 0, c_br};
        vecs[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, c_def};
        vecs[8]  = '{0, 0, 0, 0, 0, 0, 0, 1, c_frz};
        vecs[9]  = '{0, 0, 0, 0, 0, 0, 1, 1, c_frz};
        vecs[10] = '{0, 0, 0, 0, 0, 0, 0, 1, c_frz};
        vecs[11] = '{0, 0, 0, 0, 0, 0, 0, 0, c_br};
        vecs[12] = '{0, 0, 0, 0, 0, 0, 0, 0, c_def};
        vecs[13] = '{9, 0, 1, 0, 9, 1, 0, 1, c_frz};
        vecs[14] = '{9, 0, 1, 0, 9, 1, 0, 0, c_lu};
        vecs[15] = '{0, 0, 0, 0, 0, 0, 0, 0, c_def};
        vecs[16] = '{0, 0, 0, 0, 0, 0, 1, 1, c_frz};
        vecs[17] = '{0, 0, 0, 0, 0, 0, 0, 0, c_br};
        vecs[18] = '{0, 0, 0, 0, 0, 0, 0, 0, c_def};

        rst = 1'b1;
        drive(vecs[0]);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_state", 32'(outs()), 32'(c_def));

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i]);
            check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
        end

        // Busy held: no fault through five busy cycles, FAULT after edge 5.
        v = '{0, 0, 0, 0, 0, 0, 0, 1, c_frz};
        for (int i = 0; i < 5; i++) begin
            drive(v);
            check($sformatf("timeout_wait%0d", i), 32'(outs()), 32'(c_frz));
        end
        drive(v);
        check("timeout_fault", 32'(outs()), 32'(c_flt));

        // Fault is sticky and ignores branch/load-use once busy drops.
        v = '{5, 0, 1, 0, 5, 1, 1, 0, c_flt};
        drive(v);
        check("fault_sticky_br", 32'(outs()), 32'(c_flt));
        v = '{0, 0, 0, 0, 0, 0, 0, 0, c_flt};
        drive(v);
        check("fault_sticky_idle", 32'(outs()), 32'(c_flt));

        do_reset();
        #1;
        check("fault_cleared", 32'(outs()), 32'(c_def));

        // Reset mid-wait discards a pending branch.
        v = '{0, 0, 0, 0, 0, 0, 1, 1, c_frz};
        drive(v);
        check("midwait_busy", 32'(outs()), 32'(c_frz));
        v.br = 1'b0;
        drive(v);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        v = '{0, 0, 0, 0, 0, 0, 0, 0, c_def};
        drive(v);
        check("midwait_reset_no_pend", 32'(outs()), 32'(c_def));

`ifdef HAZARD_PERF_EN
        do_reset();
        #1;
        check("perf_stall_reset", hz.stall_cnt, 32'd0);
        check("perf_flush_reset", hz.flush_cnt, 32'd0);
        v = '{5, 0, 1, 0, 5, 1, 0, 0, c_lu};
        drive(v);
        v = '{0, 0, 0, 0, 0, 0, 1, 0, c_br};
        drive(v);
        v = '{0, 0, 0, 0, 0, 0, 0, 0, c_def};
        drive(v);
        check("perf_stall_one", hz.stall_cnt, 32'd1);
        check("perf_flush_one", hz.flush_cnt, 32'd1);
        do_reset();
        #1;
        check("perf_stall_cleared", hz.stall_cnt, 32'd0);
        check("perf_flush_cleared", hz.flush_cnt, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and stall controller for the 5-stage RV32I core.
- Drives the per-stage write/hold enables and flush (bubble) controls that the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers consume.
- Detects load-use hazards and taken branches, and freezes the pipeline while data memory is busy, with a wait-timeout watchdog.

Parameters:
RA_W, 5, register-address width
TIMEOUT, 16, max consecutive dmem_busy cycles before fault (2..255)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
id_rs1  input  RA_W  rs1 of instruction in ID
id_rs2  input  RA_W  rs2 of instruction in ID
id_rs1_used  input  1  ID instruction reads rs1
id_rs2_used  input  1  ID instruction reads rs2
ex_rd  input  RA_W  rd of instruction in EX
ex_mem_read  input  1  EX instruction is a load
br_taken  input  1  branch/jump resolved taken in EX
dmem_busy  input  1  data memory not ready this cycle
pc_write  output  1  1 = PC updates; 0 = PC holds
ifid_write  output  1  1 = IF/ID captures; 0 = holds
ifid_flush  output  1  1 = IF/ID loads bubble (zero)
idex_flush  output  1  1 = ID/EX loads bubble (zero)
exmem_write  output  1  1 = EX/MEM captures; 0 = holds
memwb_flush  output  1  1 = MEM/WB loads bubble
mem_fault  output  1  sticky timeout fault

Behaviour:
- State register: RUN, MEM_WAIT, FAULT. Also a wait counter (8 bits) and a br_pend flag. All are updated on the rising edge of clk.
- Reset (rst=1 at an edge): state=RUN, counter=0, br_pend=0, mem_fault=0. Reset overrides everything, including mid-wait and FAULT.
- Outputs are a combinational decode of the current state, br_pend and inputs (zero latency).
- Default (RUN, no event): pc_write=1, ifid_write=1, exmem_write=1, all flush outputs 0.
- load_use = ex_mem_read & (ex_rd!=0) & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
- Priority within a cycle: dmem_busy > branch (br_taken or br_pend) > load_use.

RUN state:
- dmem_busy=1:
  - Drive the freeze: pc_write=0, ifid_write=0, exmem_write=0, memwb_flush=1, idex_flush=0.
  - Next state MEM_WAIT, counter=1.
  - If br_taken is also 1, set br_pend=1.
- Branch, no busy: ifid_flush=1, idex_flush=1, pc_write=1. Clear br_pend. load_use is ignored this cycle.
- load_use only: pc_write=0, ifid_write=0, idex_flush=1. Exactly one bubble, because the next cycle sees a bubble in EX.

MEM_WAIT state:
- dmem_busy=1: freeze outputs as above; counter increments.
  - Counter reaching TIMEOUT: next state FAULT.
  - br_taken latches into br_pend; br_pend is never cleared while waiting.
- dmem_busy=0: next state RUN, counter=0, and outputs this cycle follow the RUN rules. A pending branch flushes in that cycle.

FAULT state:
- mem_fault=1; pipeline frozen (freeze outputs).
- Leaves only on rst.

Counter:
- Saturates; never wraps.
- TIMEOUT consecutive busy cycles produce FAULT on the following edge.

Optional Feature:
HAZARD_PERF_EN
- With the macro: adds outputs stall_cnt[31:0] and flush_cnt[31:0], both reset to 0.
  - stall_cnt increments every cycle pc_write=0.
  - flush_cnt increments every cycle ifid_flush=1.
  - Both wrap modulo 2^32.
- Without the macro: neither port nor counter logic exists; all other behaviour is identical.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_rs1_used=1 for one cycle, then ex_mem_read=0 -> exactly one cycle with pc_write=0, ifid_write=0, idex_flush=1, then defaults.
- ex_rd=0 with a load and id_rs1=0 used -> no stall; defaults held.
- br_taken=1 with a simultaneous load_use -> ifid_flush=1, idex_flush=1, pc_write=1, no stall.
- dmem_busy high 3 cycles, br_taken pulsed in busy cycle 2 -> 3 frozen cycles (memwb_flush=1), then in the first non-busy cycle ifid_flush=idex_flush=1, then defaults.
- TIMEOUT=4, dmem_busy held high -> mem_fault=1 from the 5th edge on and stays 1 after busy drops; rst for one cycle -> mem_fault=0, state RUN, defaults.
- HAZARD_PERF_EN: run one load-use stall plus one branch -> stall_cnt=1, flush_cnt=1; rst -> both 0.
